// File: rtl/seq_detector.sv
// Serial pattern detector: matches the last len accepted bits of X against a
// runtime-programmable pattern, with overlap control and a saturating match count.
module seq_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             X,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             Y,
  output logic [CNT_W-1:0] count,
  output logic             cnt_sat
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W:0]   FILL_ONE = (LEN_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PAT_W-1:0] hist_r;
  logic [LEN_W-1:0] fill_r;
  logic             y_r;
  logic [CNT_W-1:0] count_r;
  logic             cnt_sat_r;

  logic [PAT_W-1:0] next_hist_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             len_ok_s;
  logic             fill_ok_s;
  logic             bits_eq_s;
  logic             match_s;

  // Candidate history, match decode and saturating next values
  always_comb begin
    next_hist_s = {hist_r[PAT_W-2:0], X};
    // Ones in the low len positions; len == PAT_W shifts every one out
    mask_s      = ~({PAT_W{1'b1}} << len);
    len_ok_s    = (len != {LEN_W{1'b0}}) && (len <= FILL_MAX);
    fill_ok_s   = (({1'b0, fill_r} + FILL_ONE) >= {1'b0, len});
    bits_eq_s   = (((next_hist_s ^ pattern) & mask_s) == {PAT_W{1'b0}});
    match_s     = en && !clear && len_ok_s && fill_ok_s && bits_eq_s;
    fill_inc_s  = (fill_r == FILL_MAX) ? fill_r : (fill_r + LEN_W'(1));
    cnt_next_s  = (count_r == CNT_MAX) ? count_r : (count_r + CNT_ONE);
  end

  // History, fill level, detect pulse and match counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r    <= {PAT_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      y_r       <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
      cnt_sat_r <= 1'b0;
    end else if (clear) begin
      hist_r    <= {PAT_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      y_r       <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
      cnt_sat_r <= 1'b0;
    end else if (en) begin
      hist_r <= next_hist_s;
      if (match_s) begin
        y_r       <= 1'b1;
        count_r   <= cnt_next_s;
        cnt_sat_r <= (cnt_next_s == CNT_MAX);
        // Non-overlapping mode forces a full refill before the next match
        fill_r    <= overlap ? fill_inc_s : {LEN_W{1'b0}};
      end else begin
        y_r    <= 1'b0;
        fill_r <= fill_inc_s;
      end
    end else begin
      y_r <= 1'b0;
    end
  end

  assign Y       = y_r;
  assign count   = count_r;
  assign cnt_sat = cnt_sat_r;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_seq_detector;

  localparam int PAT_W = 4;
  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             en;
  logic             x;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic             y;
  logic [7:0]       count;
  logic             cnt_sat;
  logic             y2;
  logic [1:0]       count2;
  logic             cnt_sat2;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted bits since last reset/clear/non-overlap match
  bit   q[$];
  logic exp_y;
  int   exp_cnt;
  int   exp_cnt2;

  seq_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .X(x), .pattern(pattern),
    .len(len), .overlap(overlap), .Y(y), .count(count), .cnt_sat(cnt_sat)
  );

  seq_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .X(x), .pattern(pattern),
    .len(len), .overlap(overlap), .Y(y2), .count(count2), .cnt_sat(cnt_sat2)
  );

  always #5 clk = ~clk;

  task automatic model_reset;
    q.delete();
    exp_y    = 1'b0;
    exp_cnt  = 0;
    exp_cnt2 = 0;
  endtask

  task automatic step(input logic xb, input logic e, input logic c);
    int  l;
    bit  hit;
    x     = xb;
    en    = e;
    clear = c;
    @(posedge clk);
    l = int'(len);
    if (c) begin
      model_reset();
    end else if (e) begin
      q.push_back(xb);
      if (q.size() > PAT_W) void'(q.pop_front());
      hit = (l >= 1) && (l <= PAT_W) && (q.size() >= l);
      for (int k = 0; k < PAT_W; k++)
        if (hit && k < l && q[q.size() - 1 - k] != pattern[k]) hit = 1'b0;
      exp_y = hit;
      if (hit) begin
        if (exp_cnt < 255) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
        if (!overlap) q.delete();
      end
    end else begin
      exp_y = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (y !== 1'b0 || count !== 8'd0 || cnt_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Y=%b count=%0d cnt_sat=%b, expected 0 0 0", y, count, cnt_sat);
    end
    checks++;
    if (y2 !== 1'b0 || count2 !== 2'd0 || cnt_sat2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state2: Y=%b count=%0d cnt_sat=%b, expected 0 0 0", y2, count2, cnt_sat2);
    end
  endtask

  task automatic test_overlap;
    logic [6:0] s;
    logic [6:0] ye;
    s = 7'b1011011;
    ye = 7'b0001001;
    pattern = 4'b1011; len = 3'd4; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(s[6-i], 1'b1, 1'b0);
      checks++;
      if (y !== ye[6-i]) begin
        errors++;
        $display("FAIL overlap_y sample %0d: got %b expected %b", i + 1, y, ye[6-i]);
      end
    end
    checks++;
    if (count !== 8'd2) begin
      errors++;
      $display("FAIL overlap_count: got %0d expected 2", count);
    end
  endtask

  task automatic test_nonoverlap;
    logic [11:0] s;
    logic [11:0] ye;
    s = 12'b1011_0111_1011;
    ye = 12'b0001_0000_0001;
    pattern = 4'b1011; len = 3'd4; overlap = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(s[11-i], 1'b1, 1'b0);
      checks++;
      if (y !== ye[11-i]) begin
        errors++;
        $display("FAIL nonoverlap_y sample %0d: got %b expected %b", i + 1, y, ye[11-i]);
      end
      if (i == 6) begin
        checks++;
        if (count !== 8'd1) begin
          errors++;
          $display("FAIL nonoverlap_count7: got %0d expected 1", count);
        end
      end
    end
    checks++;
    if (count !== 8'd2) begin
      errors++;
      $display("FAIL nonoverlap_count: got %0d expected 2", count);
    end
  endtask

  task automatic test_en_gap;
    logic [6:0] ev;
    logic [6:0] ye;
    ev = 7'b1100111;
    pattern = 4'b0111; len = 3'd3;
    for (int ov = 1; ov >= 0; ov--) begin
      overlap = ov[0];
      ye = ov[0] ? 7'b0000111 : 7'b0000100;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
        step(ev[6-i], ev[6-i], 1'b0);
        checks++;
        if (y !== ye[6-i]) begin
          errors++;
          $display("FAIL gap_y ov=%0d cycle %0d: got %b expected %b", ov, i + 1, y, ye[6-i]);
        end
      end
      checks++;
      if (count !== (ov[0] ? 8'd3 : 8'd1)) begin
        errors++;
        $display("FAIL gap_count ov=%0d: got %0d expected %0d", ov, count, ov[0] ? 3 : 1);
      end
    end
  endtask

  task automatic test_saturate;
    logic [5:0] ye;
    logic [1:0] ce [6];
    logic [5:0] se;
    ye = 6'b011111;
    se = 6'b000111;
    ce = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pattern = 4'b0011; len = 3'd2; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (y2 !== ye[5-i] || count2 !== ce[i] || cnt_sat2 !== se[5-i]) begin
        errors++;
        $display("FAIL sat_step %0d: Y=%b count=%0d cnt_sat=%b, expected %b %0d %b",
                 i + 1, y2, count2, cnt_sat2, ye[5-i], ce[i], se[5-i]);
      end
    end
    checks++;
    if (count !== 8'd5 || cnt_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_wide: count=%0d cnt_sat=%b, expected 5 0", count, cnt_sat);
    end
  endtask

  task automatic test_async_reset;
    logic [5:0] s;
    s = 6'b101101;
    pattern = 4'b1011; len = 3'd4; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(s[5-i], 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (y !== 1'b0 || count !== 8'd0 || cnt_sat !== 1'b0 || count2 !== 2'd0) begin
      errors++;
      $display("FAIL async_rst: Y=%b count=%0d cnt_sat=%b count2=%0d, expected 0", y, count, cnt_sat, count2);
    end
    model_reset();
    @(negedge clk) rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (y !== 1'b0) begin
      errors++;
      $display("FAIL rst_single_one: got %b expected 0", y);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (y !== 1'b1 || count !== 8'd1) begin
      errors++;
      $display("FAIL rst_refill: Y=%b count=%0d, expected 1 1", y, count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (y !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL async_rst_pulse: Y=%b count=%0d, expected 0 0", y, count);
    end
    model_reset();
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_illegal_len;
    logic [7:0] s;
    s = 8'b1011_1011;
    pattern = 4'b1011; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    for (int l = 0; l < 2; l++) begin
      len = (l == 0) ? 3'd0 : 3'd5;
      for (int i = 0; i < 8; i++) begin
        step(s[7-i], 1'b1, 1'b0);
        checks++;
        if (y !== 1'b0) begin
          errors++;
          $display("FAIL illegal_y len=%0d sample %0d: got %b expected 0", len, i + 1, y);
        end
      end
    end
    checks++;
    if (count !== 8'd0) begin
      errors++;
      $display("FAIL illegal_count: got %0d expected 0", count);
    end
    len = 3'd4;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (y !== 1'b1 || count !== 8'd1) begin
      errors++;
      $display("FAIL illegal_hist_kept: Y=%b count=%0d, expected 1 1", y, count);
    end
  endtask

  task automatic test_clear_en;
    pattern = 4'b1011; len = 3'd4; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (y !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL clear_en: Y=%b count=%0d, expected 0 0", y, count);
    end
    pattern = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (y !== (i == 3)) begin
        errors++;
        $display("FAIL clear_fill sample %0d: got %b expected %b", i + 1, y, i == 3);
      end
    end
  endtask

  task automatic test_random;
    logic xb, e, c;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        pattern = 4'($urandom);
        len     = 3'($urandom_range(0, 7));
        overlap = 1'($urandom);
      end
      xb = 1'($urandom);
      e  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 59) == 0);
      step(xb, e, c);
      checks++;
      if (y !== exp_y || y2 !== exp_y) begin
        errors++;
        $display("FAIL rand_y cycle %0d: got %b/%b expected %b", n, y, y2, exp_y);
      end
      checks++;
      if (count !== 8'(exp_cnt) || cnt_sat !== (exp_cnt == 255)) begin
        errors++;
        $display("FAIL rand_count cycle %0d: got %0d sat=%b expected %0d", n, count, cnt_sat, exp_cnt);
      end
      checks++;
      if (count2 !== 2'(exp_cnt2) || cnt_sat2 !== (exp_cnt2 == 3)) begin
        errors++;
        $display("FAIL rand_count2 cycle %0d: got %0d sat=%b expected %0d", n, count2, cnt_sat2, exp_cnt2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; en = 1'b0; x = 1'b0;
    pattern = 4'b0000; len = 3'd4; overlap = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst = 1'b0;
    test_overlap();
    test_nonoverlap();
    test_en_gap();
    test_saturate();
    test_async_reset();
    test_illegal_len();
    test_clear_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
